// File: rtl/spi_slave_core.sv
// SPI mode-0 slave: oversampled sclk/ss_n/mosi and an MSB-first shift path.
// The host side uses parallel transmit and receive byte buffers with ld/rd strobes.
module spi_slave_core #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              mclk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din_slave,
    input  logic              ld_slave,
    input  logic              rd_slave,
    output logic [DATA_W-1:0] dout_slave,
    output logic              rx_valid,
    output logic              tx_empty,
    output logic              overrun,
    output logic              busy,
    input  logic              sclk,
    input  logic              ss_n,
    input  logic              mosi,
    output logic              miso
);

    localparam int               CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] sclk_q, ss_q, mosi_q;
    logic                   sclk_d, ss_d;
    logic                   sclk_s, ss_s, mosi_s;
    logic                   sclk_rise, sclk_fall, ss_fall;

    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] rx_sh, tx_sh, tx_buf, rx_buf;
    logic              start_frame, abort_frame, shift_rx, shift_tx, load_tx;

    // NOTE: the select chain resets to the idle bus level (high) so leaving reset never fakes an ss_n edge.
    always_ff @(posedge mclk or negedge rst) begin
        if (!rst) begin
            sclk_q <= '0;
            ss_q   <= '1;
            mosi_q <= '0;
            sclk_d <= 1'b0;
            ss_d   <= 1'b1;
        end else begin
            sclk_q <= {sclk_q[SYNC_STAGES-2:0], sclk};
            ss_q   <= {ss_q[SYNC_STAGES-2:0], ss_n};
            mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
            sclk_d <= sclk_q[SYNC_STAGES-1];
            ss_d   <= ss_q[SYNC_STAGES-1];
        end
    end

    assign sclk_s    = sclk_q[SYNC_STAGES-1];
    assign ss_s      = ss_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign ss_fall   = ~ss_s & ss_d;

    always_ff @(posedge mclk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // NOTE: every output of this block is given a default first, so no path can infer a latch.
    always_comb begin
        state_nxt   = state;
        start_frame = 1'b0;
        abort_frame = 1'b0;
        shift_rx    = 1'b0;
        shift_tx    = 1'b0;
        load_tx     = 1'b0;
        case (state)
            IDLE: begin
                if (ss_fall) begin
                    state_nxt   = SHIFT;
                    start_frame = 1'b1;
                    load_tx     = 1'b1;
                end
            end
            SHIFT: begin
                if (ss_s) begin
                    state_nxt   = IDLE;
                    abort_frame = 1'b1;
                end else begin
                    if (sclk_rise) begin
                        shift_rx = 1'b1;
                        if (bit_cnt == LAST_BIT) state_nxt = DONE;
                    end
                    // The falling edge after the last bit of a byte reloads the transmit shifter.
                    if (sclk_fall) begin
                        if (bit_cnt == '0) load_tx  = 1'b1;
                        else               shift_tx = 1'b1;
                    end
                end
            end
            DONE:    state_nxt = ss_s ? IDLE : SHIFT;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge mclk or negedge rst) begin
        if (!rst) begin
            bit_cnt  <= '0;
            rx_sh    <= '0;
            tx_sh    <= '0;
            tx_buf   <= '0;
            rx_buf   <= '0;
            rx_valid <= 1'b0;
            tx_empty <= 1'b1;
            overrun  <= 1'b0;
        end else begin
            if (start_frame || abort_frame) bit_cnt <= '0;
            else if (shift_rx)              bit_cnt <= bit_cnt + 1'b1;

            if (abort_frame)   rx_sh <= '0;
            else if (shift_rx) rx_sh <= {rx_sh[DATA_W-2:0], mosi_s};

            if (load_tx) begin
                tx_sh    <= tx_buf;
                tx_empty <= 1'b1;
            end else if (shift_tx) begin
                tx_sh <= tx_sh << 1;
            end

            // NOTE: a later non-blocking assignment in the same cycle wins, so a host load overrides the empty flag.
            if (ld_slave) begin
                tx_buf   <= din_slave;
                tx_empty <= 1'b0;
            end

            if (rd_slave) begin
                rx_valid <= 1'b0;
                overrun  <= 1'b0;
            end
            if (state == DONE) begin
                rx_buf   <= rx_sh;
                rx_valid <= 1'b1;
                if (rx_valid && !rd_slave) overrun <= 1'b1;
            end
        end
    end

    assign dout_slave = rx_buf;
    assign busy       = (state != IDLE);
    assign miso       = ~ss_s & tx_sh[DATA_W-1];

endmodule

// File: tb/tb_spi_slave_core.sv
// Self-checking bench for spi_slave_core: a bit-banged SPI master plus a byte-level host/link model.
module tb_spi_slave_core;

    localparam int DATA_W = 8;
    localparam int SYNC   = 2;
    localparam int HALF   = SYNC + 2;  // mclk cycles per sclk phase

    logic              mclk = 1'b0;
    logic              rst  = 1'b0;
    logic [DATA_W-1:0] din_slave = '0;
    logic              ld_slave  = 1'b0;
    logic              rd_slave  = 1'b0;
    logic [DATA_W-1:0] dout_slave;
    logic              rx_valid, tx_empty, overrun, busy;
    logic              sclk = 1'b0;
    logic              ss_n = 1'b1;
    logic              mosi = 1'b0;
    logic              miso;

    int n_checks = 0;
    int n_fail   = 0;

    // Byte-level model: host buffers plus the byte queued for the next frame.
    logic [DATA_W-1:0] m_tx_buf, m_next_tx, m_dout;
    logic              m_txe, m_rxv, m_ovr;

    spi_slave_core #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC)) dut (
        .mclk       (mclk),
        .rst        (rst),
        .din_slave  (din_slave),
        .ld_slave   (ld_slave),
        .rd_slave   (rd_slave),
        .dout_slave (dout_slave),
        .rx_valid   (rx_valid),
        .tx_empty   (tx_empty),
        .overrun    (overrun),
        .busy       (busy),
        .sclk       (sclk),
        .ss_n       (ss_n),
        .mosi       (mosi),
        .miso       (miso)
    );

    always #5 mclk = ~mclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [DATA_W+3:0] dut_stat();
        return {dout_slave, rx_valid, tx_empty, overrun, busy};
    endfunction

    function automatic logic [DATA_W+3:0] mod_stat(input logic exp_busy);
        return {m_dout, m_rxv, m_txe, m_ovr, exp_busy};
    endfunction

    function automatic void m_reset();
        m_tx_buf = '0; m_next_tx = '0; m_dout = '0;
        m_txe = 1'b1; m_rxv = 1'b0; m_ovr = 1'b0;
    endfunction

    function automatic void m_ld(input logic [DATA_W-1:0] v);
        m_tx_buf = v;
        m_txe    = 1'b0;
    endfunction

    function automatic void m_reload();
        m_next_tx = m_tx_buf;
        m_txe     = 1'b1;
    endfunction

    function automatic void m_complete(input logic [DATA_W-1:0] b, input bit rd_same);
        if (rd_same)    m_ovr = 1'b0;
        else if (m_rxv) m_ovr = 1'b1;
        m_rxv  = 1'b1;
        m_dout = b;
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(posedge mclk);
        #1;
    endtask

    task automatic do_ld(input logic [DATA_W-1:0] v);
        din_slave = v; ld_slave = 1'b1;
        cycles(1);
        ld_slave = 1'b0;
        m_ld(v);
    endtask

    task automatic do_rd();
        rd_slave = 1'b1;
        cycles(1);
        rd_slave = 1'b0;
        m_rxv = 1'b0; m_ovr = 1'b0;
    endtask

    task automatic ss_low();
        ss_n = 1'b0;
        m_reload();
    endtask

    task automatic ss_high();
        ss_n = 1'b1;
        cycles(HALF);
    endtask

    // One master frame of nbits; optional host load before bit ld_bit and rd in the DONE cycle.
    task automatic spi_frame(input logic [DATA_W-1:0] mo, input int nbits, input int ld_bit,
                             input logic [DATA_W-1:0] ld_val, input bit rd_done,
                             output logic [DATA_W-1:0] mi, output int lat);
        logic was;
        mi  = '0;
        lat = 0;
        for (int i = 0; i < nbits; i++) begin
            mosi = mo[DATA_W-1-i];
            if (i == ld_bit) begin
                din_slave = ld_val; ld_slave = 1'b1;
                cycles(1);
                ld_slave = 1'b0;
                m_ld(ld_val);
                cycles(HALF - 1);
            end else begin
                cycles(HALF);
            end
            sclk = 1'b1;
            mi[DATA_W-1-i] = miso;
            was = rx_valid;
            for (int k = 1; k <= HALF; k++) begin
                if (rd_done && i == DATA_W - 1 && k == SYNC + 2) rd_slave = 1'b1;
                cycles(1);
                rd_slave = 1'b0;
                if (lat == 0 && !was && rx_valid) lat = k;
            end
            sclk = 1'b0;
        end
        if (nbits == DATA_W) m_complete(mo, rd_done);
        cycles(HALF);
        if (nbits == DATA_W) m_reload();
    endtask

    task automatic test_reset();
        m_reset();
        rst = 1'b0;
        cycles(3);
        n_checks++;
        if (dut_stat() !== mod_stat(1'b0)) begin
            n_fail++;
            $display("FAIL reset_status: got %h expected %h", dut_stat(), mod_stat(1'b0));
        end
        n_checks++;
        if (miso !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_miso: got %b expected 0", miso);
        end
        rst = 1'b1;
        cycles(2);
    endtask

    task automatic test_basic();
        logic [DATA_W-1:0] mi, exp_mi;
        int lat;
        do_ld(8'hA5);
        ss_low();
        exp_mi = m_next_tx;
        spi_frame(8'h3C, DATA_W, -1, '0, 1'b0, mi, lat);
        n_checks++;
        if (mi !== exp_mi) begin
            n_fail++;
            $display("FAIL basic_miso: got %h expected %h", mi, exp_mi);
        end
        n_checks++;
        if (lat !== SYNC + 2) begin
            n_fail++;
            $display("FAIL basic_rx_latency: got %0d expected %0d", lat, SYNC + 2);
        end
        n_checks++;
        if (dut_stat() !== mod_stat(1'b1)) begin
            n_fail++;
            $display("FAIL basic_status: got %h expected %h", dut_stat(), mod_stat(1'b1));
        end
        ss_high();
        n_checks++;
        if (dut_stat() !== mod_stat(1'b0)) begin
            n_fail++;
            $display("FAIL basic_idle: got %h expected %h", dut_stat(), mod_stat(1'b0));
        end
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] mi, exp_mi;
        logic [DATA_W-1:0] data [2] = '{8'h11, 8'h22};
        int lat;
        do_rd();
        do_ld(8'hF0);
        ss_low();
        for (int f = 0; f < 2; f++) begin
            exp_mi = m_next_tx;
            spi_frame(data[f], DATA_W, (f == 0) ? 3 : -1, 8'h0F, 1'b0, mi, lat);
            n_checks++;
            if (mi !== exp_mi) begin
                n_fail++;
                $display("FAIL b2b_miso[%0d]: got %h expected %h", f, mi, exp_mi);
            end
            n_checks++;
            if (dut_stat() !== mod_stat(1'b1)) begin
                n_fail++;
                $display("FAIL b2b_status[%0d]: got %h expected %h", f, dut_stat(), mod_stat(1'b1));
            end
            do_rd();
            n_checks++;
            if (dut_stat() !== mod_stat(1'b1)) begin
                n_fail++;
                $display("FAIL b2b_after_rd[%0d]: got %h expected %h", f, dut_stat(), mod_stat(1'b1));
            end
        end
        ss_high();
    endtask

    task automatic test_overrun();
        logic [DATA_W-1:0] mi, exp_mi;
        logic [DATA_W-1:0] data [2] = '{8'h55, 8'hAA};
        int lat;
        ss_low();
        for (int f = 0; f < 2; f++) begin
            exp_mi = m_next_tx;
            spi_frame(data[f], DATA_W, -1, '0, 1'b0, mi, lat);
            n_checks++;
            if (mi !== exp_mi) begin
                n_fail++;
                $display("FAIL ovr_miso[%0d]: got %h expected %h", f, mi, exp_mi);
            end
        end
        n_checks++;
        if (dut_stat() !== mod_stat(1'b1)) begin
            n_fail++;
            $display("FAIL ovr_set: got %h expected %h", dut_stat(), mod_stat(1'b1));
        end
        do_rd();
        n_checks++;
        if (dut_stat() !== mod_stat(1'b1)) begin
            n_fail++;
            $display("FAIL ovr_clear: got %h expected %h", dut_stat(), mod_stat(1'b1));
        end
        ss_high();
    endtask

    task automatic test_partial();
        logic [DATA_W-1:0] mi;
        int lat;
        ss_low();
        spi_frame(8'hFF, 5, -1, '0, 1'b0, mi, lat);
        ss_high();
        n_checks++;
        if (dut_stat() !== mod_stat(1'b0)) begin
            n_fail++;
            $display("FAIL partial_abort: got %h expected %h", dut_stat(), mod_stat(1'b0));
        end
        ss_low();
        spi_frame(8'h81, DATA_W, -1, '0, 1'b0, mi, lat);
        n_checks++;
        if (dut_stat() !== mod_stat(1'b1)) begin
            n_fail++;
            $display("FAIL partial_next: got %h expected %h", dut_stat(), mod_stat(1'b1));
        end
        do_rd();
        ss_high();
    endtask

    task automatic test_rd_in_done();
        logic [DATA_W-1:0] mi, b1, b2;
        int lat;
        b1 = DATA_W'($urandom());
        b2 = DATA_W'($urandom());
        ss_low();
        spi_frame(b1, DATA_W, -1, '0, 1'b0, mi, lat);
        spi_frame(b2, DATA_W, -1, '0, 1'b1, mi, lat);
        n_checks++;
        if (dut_stat() !== mod_stat(1'b1)) begin
            n_fail++;
            $display("FAIL rd_in_done: got %h expected %h", dut_stat(), mod_stat(1'b1));
        end
        do_rd();
        ss_high();
    endtask

    task automatic test_reset_mid_frame();
        logic [DATA_W-1:0] mi, exp_mi;
        int lat;
        ss_low();
        spi_frame(DATA_W'($urandom()), 4, -1, '0, 1'b0, mi, lat);
        rst = 1'b0;
        m_reset();
        cycles(1);
        n_checks++;
        if ({dut_stat(), miso} !== {mod_stat(1'b0), 1'b0}) begin
            n_fail++;
            $display("FAIL midrst_status: got %h expected %h", {dut_stat(), miso}, {mod_stat(1'b0), 1'b0});
        end
        ss_n = 1'b1;
        cycles(1);
        rst = 1'b1;
        cycles(HALF);
        do_ld(DATA_W'($urandom()));
        ss_low();
        exp_mi = m_next_tx;
        spi_frame(8'h7E, DATA_W, -1, '0, 1'b0, mi, lat);
        n_checks++;
        if (mi !== exp_mi) begin
            n_fail++;
            $display("FAIL midrst_miso: got %h expected %h", mi, exp_mi);
        end
        n_checks++;
        if (dut_stat() !== mod_stat(1'b1)) begin
            n_fail++;
            $display("FAIL midrst_next: got %h expected %h", dut_stat(), mod_stat(1'b1));
        end
        do_rd();
        ss_high();
    endtask

    task automatic test_random();
        logic [DATA_W-1:0] mi, exp_mi, b;
        int lat, nfr;
        for (int it = 0; it < 12; it++) begin
            if ($urandom_range(1) == 1) do_ld(DATA_W'($urandom()));
            ss_low();
            nfr = int'($urandom_range(3, 1));
            for (int f = 0; f < nfr; f++) begin
                exp_mi = m_next_tx;
                b = DATA_W'($urandom());
                spi_frame(b, DATA_W, -1, '0, 1'b0, mi, lat);
                n_checks++;
                if (mi !== exp_mi) begin
                    n_fail++;
                    $display("FAIL rand_miso[%0d.%0d]: got %h expected %h", it, f, mi, exp_mi);
                end
                if ($urandom_range(2) != 0) do_rd();
                n_checks++;
                if (dut_stat() !== mod_stat(1'b1)) begin
                    n_fail++;
                    $display("FAIL rand_status[%0d.%0d]: got %h expected %h", it, f, dut_stat(), mod_stat(1'b1));
                end
            end
            ss_high();
            n_checks++;
            if (dut_stat() !== mod_stat(1'b0)) begin
                n_fail++;
                $display("FAIL rand_idle[%0d]: got %h expected %h", it, dut_stat(), mod_stat(1'b0));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_overrun();
        test_partial();
        test_rd_in_done();
        test_reset_mid_frame();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
